// File: rtl/ram_access_ctrl.sv
// Bus initiator for the negedge single-port RAM: turns single or burst
// read/write requests into chip-select-gated RAM cycles with read backpressure.
module ram_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              done,
    output logic              busy,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        WRITE,
        READ,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, next_addr;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic              cs_d, we_d, rvalid_d, rlast_d, done_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d, rdata_d;

    assign req_ready   = (state_q == IDLE);
    assign wdata_ready = (state_q == WWAIT);
    assign next_addr   = cur_addr_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        beats_d    = beats_q;
        cs_d       = ram_cs;
        we_d       = ram_we;
        addr_d     = ram_address;
        din_d      = ram_data_in;
        rvalid_d   = resp_valid;
        rlast_d    = resp_last;
        rdata_d    = resp_data;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cur_addr_d = req_addr;
                    beats_d    = req_len;
                    if (req_write) begin
                        state_d = WWAIT;
                    end else begin
                        state_d = READ;
                        cs_d    = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = req_addr;
                    end
                end
            end
            WWAIT: begin
                if (wdata_valid) begin
                    state_d = WRITE;
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = cur_addr_q;
                    din_d   = wdata;
                end
            end
            WRITE: begin
                cs_d       = 1'b0;
                we_d       = 1'b0;
                cur_addr_d = next_addr;
                if (beats_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    beats_d = beats_q - LEN_W'(1);
                    state_d = WWAIT;
                end
            end
            READ: begin
                cs_d     = 1'b0;
                rdata_d  = ram_data_out;
                rvalid_d = 1'b1;
                rlast_d  = (beats_q == '0);
                state_d  = RESP;
            end
            RESP: begin
                // Response registers hold until the consumer takes the beat.
                if (resp_ready) begin
                    rvalid_d   = 1'b0;
                    rlast_d    = 1'b0;
                    cur_addr_d = next_addr;
                    if (beats_q != '0) begin
                        beats_d = beats_q - LEN_W'(1);
                        state_d = READ;
                        cs_d    = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = next_addr;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            beats_q     <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            resp_valid  <= 1'b0;
            resp_last   <= 1'b0;
            resp_data   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            beats_q     <= beats_d;
            ram_cs      <= cs_d;
            ram_we      <= we_d;
            ram_address <= addr_d;
            ram_data_in <= din_d;
            resp_valid  <= rvalid_d;
            resp_last   <= rlast_d;
            resp_data   <= rdata_d;
            done        <= done_d;
            busy        <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: negedge RAM model, transaction-level memory
// reference, directed scenarios plus randomized bursts.
module tb_ram_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int LW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          resp_valid, resp_ready, resp_last;
    logic [DW-1:0] resp_data;
    logic          done, busy, ram_cs, ram_we;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in, ram_data_out;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram     [2048] = '{default: '0};
    logic [DW-1:0] ref_mem [2048] = '{default: '0};
    logic [AW+DW-1:0] exp_wr[$];
    logic prev_cs = 1'b0;

    always #5 clock = ~clock;

    ram_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_last(resp_last),
        .done(done), .busy(busy),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // Single-port RAM acting on the falling edge, only when selected.
    always @(negedge clock) begin
        if (ram_cs) begin
            if (ram_we) ram[ram_address] <= ram_data_in;
            else ram_data_out <= ram[ram_address];
        end else begin
            ram_data_out <= 'z;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus-side protocol monitor.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            prev_cs = 1'b0;
        end else begin
            chk("cs_pair", {63'd0, prev_cs & ram_cs}, 64'd0);
            if (ram_we) chk("we_cs", {63'd0, ram_cs}, 64'd1);
            if (ram_cs && ram_we) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexp", 64'd1, 64'd0);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", {53'd0, ram_address}, {53'd0, e[AW+DW-1:DW]});
                    chk("wr_data", {32'd0, ram_data_in}, {32'd0, e[DW-1:0]});
                end
            end
            prev_cs = ram_cs;
        end
    end

    task automatic issue_req(input logic wr, input logic [AW-1:0] a, input int len);
        int n;
        req_write = wr;
        req_addr  = a;
        req_len   = LW'(len);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic write_beats(input logic [AW-1:0] addr, input int len,
                               input logic [DW-1:0] d0, input bit rnd, input bit gaps);
        for (int i = 0; i <= len; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int g;
            a = addr + AW'(i);
            d = rnd ? $urandom : d0 + DW'(i);
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                @(posedge clock); #1;
                chk("gap_cs", {63'd0, ram_cs}, 64'd0);
            end
            chk("wdata_ready", {63'd0, wdata_ready}, 64'd1);
            wdata_valid = 1'b1;
            wdata = d;
            exp_wr.push_back({a, d});
            @(posedge clock); #1;
            wdata_valid = 1'b0;
            chk("wr_cs", {62'd0, ram_cs, ram_we}, 64'd3);
            ref_mem[a] = d;
            @(posedge clock); #1;
            chk("wr_done", {63'd0, done}, {63'd0, i == len});
        end
    endtask

    task automatic read_beats(input logic [AW-1:0] addr, input int len,
                              input int stall_beat, input int stall_n);
        for (int i = 0; i <= len; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] held;
            int cyc;
            int k;
            a = addr + AW'(i);
            chk("rd_cs", {62'd0, ram_cs, ram_we}, 64'd2);
            chk("rd_addr", {53'd0, ram_address}, {53'd0, a});
            cyc = 0;
            do begin
                @(posedge clock); #1;
                cyc++;
            end while (!resp_valid && cyc < 50);
            chk("rd_lat", 64'(cyc), 64'd1);
            chk("rd_data", {32'd0, resp_data}, {32'd0, ref_mem[a]});
            chk("rd_last", {63'd0, resp_last}, {63'd0, i == len});
            held = resp_data;
            k = (i == stall_beat) ? stall_n : $urandom_range(0, 2);
            repeat (k) begin
                @(posedge clock); #1;
                chk("hold", {31'd0, resp_valid, resp_data}, {31'd0, 1'b1, held});
            end
            resp_ready = 1'b1;
            @(posedge clock); #1;
            resp_ready = 1'b0;
            chk("rd_vclr", {63'd0, resp_valid}, 64'd0);
            chk("rd_done", {63'd0, done}, {63'd0, i == len});
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out", {resp_valid, resp_last, done, busy, ram_cs, ram_we},
            64'd0);
        chk("rst_bus", {ram_address, ram_data_in}, 64'd0);
        chk("rst_rdata", {32'd0, resp_data}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        issue_req(1'b1, 11'h005, 0);
        write_beats(11'h005, 0, 32'hDEADBEEF, 1'b0, 1'b0);

        issue_req(1'b0, 11'h005, 0);
        read_beats(11'h005, 0, -1, 0);

        issue_req(1'b1, 11'h7FE, 3);
        write_beats(11'h7FE, 3, 32'd1, 1'b0, 1'b1);
        chk("wrap_ram", {32'd0, ram[0]}, 64'd3);

        issue_req(1'b0, 11'h7FE, 3);
        read_beats(11'h7FE, 3, 1, 3);

        // Reset while a read burst is waiting in its second response beat.
        issue_req(1'b0, 11'h7FE, 3);
        @(posedge clock); #1;
        chk("ab_v0", {63'd0, resp_valid}, 64'd1);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        @(posedge clock); #1;
        chk("ab_v1", {63'd0, resp_valid}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("ab_out", {resp_valid, resp_last, done, busy, ram_cs, ram_we}, 64'd0);
        chk("ab_bus", {ram_address, resp_data}, 64'd0);
        repeat (2) begin
            @(posedge clock); #1;
            chk("ab_nodone", {63'd0, done}, 64'd0);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        chk("ab_ready", {62'd0, req_ready, done}, 64'd2);
        issue_req(1'b0, 11'h7FF, 0);
        read_beats(11'h7FF, 0, -1, 0);

        // Back-to-back: second request held pending across the done cycle.
        issue_req(1'b1, 11'h100, 1);
        req_write = 1'b0; req_addr = 11'h100; req_len = 4'd1; req_valid = 1'b1;
        write_beats(11'h100, 1, 32'hA5A50000, 1'b0, 1'b1);
        chk("b2b_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        read_beats(11'h100, 1, -1, 0);

        for (int t = 0; t < 30; t++) begin
            logic [AW-1:0] a;
            int len;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(2040, 2047))
                                            : AW'($urandom_range(0, 2047));
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                issue_req(1'b1, a, len);
                write_beats(a, len, '0, 1'b1, 1'b1);
            end else begin
                issue_req(1'b0, a, len);
                read_beats(a, len, -1, 0);
            end
        end

        chk("wr_drain", 64'(exp_wr.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
